dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: LOCK_MAX, default 16, maximum consecutive cycles one port may hold a lock.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset: asserted when 0, takes effect immediately regardless of clk.
REQ-004 req0  input  1  port 0 (pipeline load/store) access request.
REQ-005 we0  input  1  port 0 write enable (1 = store, 0 = load).
REQ-006 addr0  input  32  port 0 byte address.
REQ-007 wdata0  input  32  port 0 store data.
REQ-008 lock0  input  1  port 0 requests to keep ownership after this access.
REQ-009 gnt0  output  1  port 0 access accepted this cycle.
REQ-010 rvalid0  output  1  port 0 response valid, one cycle after gnt0.
REQ-011 rdata0  output  32  port 0 load data.
REQ-012 err0  output  1  port 0 misaligned-access error, qualified by rvalid0.
REQ-013 req1, we1, addr1, wdata1, lock1, gnt1, rvalid1, rdata1, err1: port 1 (loader/debug) signals, same widths and meanings as port 0.
REQ-014 mem_A  output  32  byte address to data memory (memory word-indexes by A[31:2]).
REQ-015 mem_WE  output  1  data memory write enable.
REQ-016 mem_WD  output  32  data memory write data.
REQ-017 mem_RD  input  32  data memory combinational read data.

Function
REQ-018 Grant decision SHALL be combinational in the request cycle; at most one of gnt0/gnt1 high in any cycle.
REQ-019 States: IDLE, OWN0, OWN1; reg last (port granted most recently); lock counter lcnt, sized to hold LOCK_MAX.
REQ-020 IDLE, one port requesting: that port granted.
REQ-021 IDLE, both requesting: port != last granted (round-robin).
REQ-022 OWNx: only port x may be granted; other port's gnt SHALL be 0 even if requesting.
REQ-023 IDLE -> OWNx when port x granted with lockx=1; lcnt loads 1.
REQ-024 OWNx, req x and lock x high, lcnt < LOCK_MAX: grant x, stay, lcnt increments.
REQ-025 OWNx, lock x low or req x low: access (if req) granted normally, state -> IDLE, lcnt -> 0.
REQ-026 OWNx, lcnt == LOCK_MAX: x not granted that cycle; state -> IDLE, last = x, so a pending other port wins next cycle.
REQ-027 Granted port drives mem_A/mem_WD; mem_WE = gnt & we & aligned; when no grant, mem_WE = 0, mem_A/mem_WD = 0.
REQ-028 Aligned means addr[1:0] == 2'b00; misaligned access is granted and consumed but SHALL NOT write memory.
REQ-029 Response: cycle after grant, rvalidx = 1 for exactly one cycle; rdatax = mem_RD sampled at grant edge for loads, 0 for stores and misaligned; errx = 1 iff misaligned.
REQ-030 rdatax SHALL hold its value until the next response on that port.
REQ-031 Back-to-back grants on one port SHALL yield back-to-back rvalid pulses; throughput one access per cycle.
REQ-032 last updates on every grant to the granted port.

Reset
REQ-033 While rst = 0: state IDLE, last = 1 (port 0 wins first tie), lcnt = 0, rvalid0/1 = 0, rdata0/1 = 0, err0/1 = 0, gnt0/1 = 0, mem_WE = 0.
REQ-034 Reset asserted mid-lock SHALL drop ownership immediately; an access whose grant edge coincides with reset assertion SHALL produce no response.

Verification
REQ-035 Both req from reset, we=0, addr0=0x10, addr1=0x20 -> gnt0 first cycle, gnt1 next; rdata0=mem[4], rdata1=mem[8], each rvalid one cycle later.
REQ-036 req0 store addr=0x8 wdata=0xDEADBEEF, then load 0x8 -> mem_WE pulse on store; load returns 0xDEADBEEF, err0=0.
REQ-037 req1 store addr=0x6 -> gnt1=1, mem_WE=0, next cycle rvalid1=1, err1=1, rdata1=0; memory unchanged.
REQ-038 port0 lock0=1 for 20 cycles with req1 held high, LOCK_MAX=16 -> gnt0 for 16 cycles, cycle 17 no grant, cycle 18 gnt1=1.
REQ-039 rst driven low asynchronously during OWN1 with responses pending -> outputs clear immediately; after release, first tie goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin between pipeline (port 0) and loader (port 1),
// with bounded lock ownership and a one-cycle registered response per port.
module dmem_arbiter #(
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        lock0,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [31:0] rdata0,
    output logic        err0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        lock1,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic [31:0] mem_A,
    output logic        mem_WE,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state;
    logic            last;
    logic [CW-1:0]   lcnt;
    logic            g0, g1, at_max, sel_we;
    logic            misal0, misal1;

    assign at_max = (lcnt == LMAX);
    assign misal0 = (addr0[1:0] != 2'b00);
    assign misal1 = (addr1[1:0] != 2'b00);

    // Grants are gated by reset so nothing reaches memory while rst is low.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (req0 && req1) begin
                        g0 = last;
                        g1 = !last;
                    end else begin
                        g0 = req0;
                        g1 = req1;
                    end
                end
                OWN0:    g0 = req0 && !at_max;
                OWN1:    g1 = req1 && !at_max;
                default: ;
            endcase
        end
    end

    assign gnt0   = g0;
    assign gnt1   = g1;
    assign sel_we = g0 ? we0 : (g1 & we1);
    assign mem_A  = g0 ? addr0  : (g1 ? addr1  : 32'd0);
    assign mem_WD = g0 ? wdata0 : (g1 ? wdata1 : 32'd0);
    assign mem_WE = sel_we & ((g0 & !misal0) | (g1 & !misal1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            lcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (g0) begin
                        last <= 1'b0;
                        if (lock0) begin
                            state <= OWN0;
                            lcnt  <= CW'(1);
                        end
                    end else if (g1) begin
                        last <= 1'b1;
                        if (lock1) begin
                            state <= OWN1;
                            lcnt  <= CW'(1);
                        end
                    end
                end
                OWN0: begin
                    // At the limit the owner is refused and marked last so the other port wins next.
                    if (at_max) begin
                        state <= IDLE;
                        lcnt  <= '0;
                        last  <= 1'b0;
                    end else if (req0 && lock0) begin
                        lcnt  <= lcnt + 1'b1;
                        last  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        lcnt  <= '0;
                        if (g0) last <= 1'b0;
                    end
                end
                OWN1: begin
                    if (at_max) begin
                        state <= IDLE;
                        lcnt  <= '0;
                        last  <= 1'b1;
                    end else if (req1 && lock1) begin
                        lcnt  <= lcnt + 1'b1;
                        last  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        lcnt  <= '0;
                        if (g1) last <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    lcnt  <= '0;
                end
            endcase
        end
    end

    // rdata holds between responses; err is a pulse aligned with rvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= g0;
            rvalid1 <= g1;
            err0    <= g0 & misal0;
            err1    <= g1 & misal1;
            if (g0) rdata0 <= (!we0 && !misal0) ? mem_RD : 32'd0;
            if (g1) rdata1 <= (!we1 && !misal1) ? mem_RD : 32'd0;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus lock-limit and async-reset sequences.
module tb_dmem_arbiter;
    logic        clk, rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;
    logic [31:0] mem [0:255];
    int          n_vec = 0;
    int          n_err = 0;

    dmem_arbiter #(.LOCK_MAX(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
        .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i holds A000_0000+i after reset.
    assign mem_RD = mem[mem_A[9:2]];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (mem_WE) begin
            mem[mem_A[9:2]] <= mem_WD;
        end
    end

    typedef struct {
        logic        r0, w0, l0;
        logic [31:0] a0, d0;
        logic        r1, w1, l1;
        logic [31:0] a1, d1;
        logic        eg0, eg1, ewe;
        logic [31:0] ea;
        logic        erv0, erv1;
        logic [31:0] erd0, erd1;
        logic        eer0, eer1;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        //           r0 w0 l0 a0     d0            r1 w1 l1 a1     d1            g0 g1 we ea     rv0 rv1 rd0           rd1           e0 e1
        tbl[0] = '{1, 0, 0, 32'h10, 32'h0,        1, 0, 0, 32'h20, 32'h0,        1, 0, 0, 32'h10, 1, 0, 32'hA0000004, 32'h0,        0, 0};
        tbl[1] = '{1, 0, 0, 32'h10, 32'h0,        1, 0, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 0, 1, 32'hA0000004, 32'hA0000008, 0, 0};
        tbl[2] = '{1, 1, 0, 32'h08, 32'hDEADBEEF, 0, 0, 0, 32'h20, 32'h0,        1, 0, 1, 32'h08, 1, 0, 32'h0,        32'hA0000008, 0, 0};
        tbl[3] = '{1, 0, 0, 32'h08, 32'h0,        0, 0, 0, 32'h20, 32'h0,        1, 0, 0, 32'h08, 1, 0, 32'hDEADBEEF, 32'hA0000008, 0, 0};
        tbl[4] = '{0, 0, 0, 32'h08, 32'h0,        1, 1, 0, 32'h06, 32'h12345678, 0, 1, 0, 32'h06, 0, 1, 32'hDEADBEEF, 32'h0,        0, 1};
        tbl[5] = '{0, 0, 0, 32'h08, 32'h0,        1, 0, 0, 32'h04, 32'h0,        0, 1, 0, 32'h04, 0, 1, 32'hDEADBEEF, 32'hA0000001, 0, 0};
        tbl[6] = '{0, 0, 0, 32'h08, 32'h0,        0, 0, 0, 32'h04, 32'h0,        0, 0, 0, 32'h00, 0, 0, 32'hDEADBEEF, 32'hA0000001, 0, 0};
        tbl[7] = '{1, 0, 1, 32'h0C, 32'h0,        1, 0, 0, 32'h20, 32'h0,        1, 0, 0, 32'h0C, 1, 0, 32'hA0000003, 32'hA0000001, 0, 0};
        tbl[8] = '{1, 0, 0, 32'h0C, 32'h0,        1, 0, 0, 32'h20, 32'h0,        1, 0, 0, 32'h0C, 1, 0, 32'hA0000003, 32'hA0000001, 0, 0};
        tbl[9] = '{1, 0, 0, 32'h0C, 32'h0,        1, 0, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 0, 1, 32'hA0000003, 32'hA0000008, 0, 0};

        // Reset with requests active: nothing may be granted or written.
        rst = 1'b0;
        req0 = 1; we0 = 1; addr0 = 0; wdata0 = 32'h55; lock0 = 0;
        req1 = 1; we1 = 1; addr1 = 4; wdata1 = 32'h66; lock1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst gnt0", {31'd0, gnt0}, 0);
        chk("rst gnt1", {31'd0, gnt1}, 0);
        chk("rst mem_WE", {31'd0, mem_WE}, 0);
        chk("rst rvalid0", {31'd0, rvalid0}, 0);
        chk("rst rvalid1", {31'd0, rvalid1}, 0);
        chk("rst rdata0", rdata0, 0);
        chk("rst err1", {31'd0, err1}, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0; lock0 = tbl[i].l0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1; lock1 = tbl[i].l1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
            #2;
            chk($sformatf("v%0d gnt0", i), {31'd0, gnt0}, {31'd0, tbl[i].eg0});
            chk($sformatf("v%0d gnt1", i), {31'd0, gnt1}, {31'd0, tbl[i].eg1});
            chk($sformatf("v%0d mem_WE", i), {31'd0, mem_WE}, {31'd0, tbl[i].ewe});
            chk($sformatf("v%0d mem_A", i), mem_A, tbl[i].ea);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rvalid0", i), {31'd0, rvalid0}, {31'd0, tbl[i].erv0});
            chk($sformatf("v%0d rvalid1", i), {31'd0, rvalid1}, {31'd0, tbl[i].erv1});
            chk($sformatf("v%0d rdata0", i), rdata0, tbl[i].erd0);
            chk($sformatf("v%0d rdata1", i), rdata1, tbl[i].erd1);
            chk($sformatf("v%0d err0", i), {31'd0, err0}, {31'd0, tbl[i].eer0});
            chk($sformatf("v%0d err1", i), {31'd0, err1}, {31'd0, tbl[i].eer1});
            @(negedge clk);
        end

        // Lock limit: port 0 locked for 20 cycles, port 1 pending throughout.
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 32'h0;
        req1 = 1; we1 = 0; lock1 = 0; addr1 = 32'h4;
        for (int c = 1; c <= 20; c++) begin
            #2;
            chk($sformatf("lock c%0d gnt0", c), {31'd0, gnt0}, (c <= 16 || c >= 19) ? 32'd1 : 32'd0);
            chk($sformatf("lock c%0d gnt1", c), {31'd0, gnt1}, (c == 18) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            if (c == 17) begin
                chk("lock c17 rvalid0", {31'd0, rvalid0}, 0);
                chk("lock c17 rvalid1", {31'd0, rvalid1}, 0);
            end
            @(negedge clk);
        end

        // Move into OWN1 with a response pending, then reset asynchronously mid-cycle.
        req0 = 0; lock0 = 0;
        req1 = 1; lock1 = 1; we1 = 0; addr1 = 32'h10;
        #2;
        chk("own0 drop gnt0", {31'd0, gnt0}, 0);
        chk("own0 drop gnt1", {31'd0, gnt1}, 0);
        @(negedge clk);
        #2;
        chk("own1 enter gnt1", {31'd0, gnt1}, 1);
        @(posedge clk);
        #1;
        chk("own1 rvalid1", {31'd0, rvalid1}, 1);
        chk("own1 rdata1", rdata1, 32'hA0000004);
        @(negedge clk);
        #2;
        chk("own1 hold gnt1", {31'd0, gnt1}, 1);
        rst = 1'b0;
        #1;
        chk("async rvalid1", {31'd0, rvalid1}, 0);
        chk("async rdata1", rdata1, 0);
        chk("async gnt1", {31'd0, gnt1}, 0);
        chk("async mem_WE", {31'd0, mem_WE}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req0 = 1; we0 = 0; lock0 = 0; addr0 = 32'h10;
        req1 = 1; we1 = 0; lock1 = 0; addr1 = 32'h20;
        #2;
        chk("post-rst gnt0", {31'd0, gnt0}, 1);
        chk("post-rst gnt1", {31'd0, gnt1}, 0);
        @(posedge clk);
        #1;
        chk("post-rst rvalid0", {31'd0, rvalid0}, 1);
        chk("post-rst rdata0", rdata0, 32'hA0000004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
